// File: rtl/pe_array_scheduler_pkg.sv
// Shared widths, activation-type encodings and index-width helper for the
// PE array scheduler slice.
package pe_array_scheduler_pkg;

  localparam int PE_ACC_W  = 40;
  localparam int PE_DATA_W = 16;

  typedef enum logic [1:0] {
    ACT_NONE    = 2'b00,
    ACT_RELU    = 2'b01,
    ACT_SIGMOID = 2'b10,
    ACT_TANH    = 2'b11
  } act_type_e;

  typedef struct packed {
    logic [PE_DATA_W-1:0] in_data;
    logic [PE_DATA_W-1:0] wt_data;
  } operand_t;

  // Bits needed to index n PEs; never less than one so a 1-bit pointer exists.
  function automatic int idx_width(input int n);
    int w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/pe_array_scheduler_result_skid.sv
// One-entry result register between the PE collection point and writeback.
module pe_result_skid
  import pe_array_scheduler_pkg::*;
#(
  parameter int TAG_W = 8,
  parameter int IDX_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PE_ACC_W-1:0] in_data,
  input  logic [TAG_W-1:0]    in_tag,
  input  logic [IDX_W-1:0]    in_pe,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PE_ACC_W-1:0] out_data,
  output logic [TAG_W-1:0]    out_tag,
  output logic [IDX_W-1:0]    out_pe
);

  assign in_ready = !out_valid || out_ready;

  // A new capture overwrites the slot; otherwise a consumed result empties it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      out_pe    <= '0;
    end else if (in_valid) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_tag   <= in_tag;
      out_pe    <= in_pe;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pe_array_scheduler.sv
// Round-robin dispatch/collect controller for NUM_PE shared processing
// elements; results return in job-accept order with their tags.
module pe_array_scheduler
  import pe_array_scheduler_pkg::*;
#(
  parameter int  NUM_PE = 4,
  parameter int  TAG_W  = 8,
  localparam int IDX_W  = idx_width(NUM_PE)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [PE_DATA_W-1:0]       job_input,
  input  logic [PE_DATA_W-1:0]       job_weight,
  input  logic [TAG_W-1:0]           job_tag,
  output logic [NUM_PE-1:0]          pe_in_valid,
  output logic [NUM_PE-1:0]          pe_wt_valid,
  output logic [PE_DATA_W-1:0]       pe_in_data,
  output logic [PE_DATA_W-1:0]       pe_wt_data,
  input  logic [NUM_PE-1:0]          pe_in_ready,
  input  logic [NUM_PE-1:0]          pe_wt_ready,
  input  logic [PE_ACC_W*NUM_PE-1:0] pe_out_data,
  input  logic [NUM_PE-1:0]          pe_out_valid,
  output logic [NUM_PE-1:0]          pe_out_ready,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [PE_ACC_W-1:0]        res_data,
  output logic [TAG_W-1:0]           res_tag,
  output logic [IDX_W-1:0]           res_pe,
  input  logic [1:0]                 cfg_act_type,
  input  logic                       cfg_act_we,
  output logic [1:0]                 pe_act_type,
  output logic                       idle
);

  logic                 disp_v;
  operand_t             disp_op;
  logic [IDX_W-1:0]     disp_tgt;
  logic [IDX_W-1:0]     disp_ptr;
  logic [IDX_W-1:0]     gnt_ptr;
  logic [NUM_PE-1:0]    busy;
  logic [TAG_W-1:0]     tag_q [NUM_PE];
  act_type_e            act_q;
  act_type_e            act_pend_val;
  logic                 act_pend;
  logic                 disp_fire;
  logic                 job_fire;
  logic                 cap_fire;
  logic                 res_in_ready;
  logic [PE_ACC_W-1:0]  cap_data;

  // The oldest PE is held off while its own dispatch is still pending so a
  // stale result can never be collected against a freshly issued job.
  always_comb begin
    disp_fire    = disp_v & pe_in_ready[disp_tgt] & pe_wt_ready[disp_tgt];
    job_ready    = !rst & (!disp_v | disp_fire) & !busy[disp_ptr] & !act_pend;
    job_fire     = job_valid & job_ready;
    pe_in_valid  = '0;
    pe_in_valid[disp_tgt] = disp_v;
    pe_out_ready = '0;
    pe_out_ready[gnt_ptr] = busy[gnt_ptr] & !(disp_v & (disp_tgt == gnt_ptr)) & res_in_ready;
    cap_fire     = pe_out_valid[gnt_ptr] & pe_out_ready[gnt_ptr];
    cap_data     = pe_out_data[int'(gnt_ptr) * PE_ACC_W +: PE_ACC_W];
  end

  assign pe_wt_valid = pe_in_valid;
  assign pe_in_data  = disp_op.in_data;
  assign pe_wt_data  = disp_op.wt_data;
  assign pe_act_type = act_q;
  assign idle        = !disp_v & ~|busy & !res_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_v   <= 1'b0;
      disp_op  <= '0;
      disp_tgt <= '0;
      disp_ptr <= '0;
    end else if (job_fire) begin
      disp_v   <= 1'b1;
      disp_op  <= {job_input, job_weight};
      disp_tgt <= disp_ptr;
      disp_ptr <= disp_ptr + 1'b1;
    end else if (disp_fire) begin
      disp_v   <= 1'b0;
    end
  end

  // Capture clears before accept sets, so a shared index ends up busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= '0;
      gnt_ptr <= '0;
      for (int i = 0; i < NUM_PE; i++) tag_q[i] <= '0;
    end else begin
      if (cap_fire) begin
        busy[gnt_ptr] <= 1'b0;
        gnt_ptr       <= gnt_ptr + 1'b1;
      end
      if (job_fire) begin
        busy[disp_ptr]  <= 1'b1;
        tag_q[disp_ptr] <= job_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_q        <= ACT_NONE;
      act_pend     <= 1'b0;
      act_pend_val <= ACT_NONE;
    end else if (cfg_act_we && idle) begin
      act_q    <= act_type_e'(cfg_act_type);
      act_pend <= 1'b0;
    end else if (cfg_act_we) begin
      act_pend     <= 1'b1;
      act_pend_val <= act_type_e'(cfg_act_type);
    end else if (act_pend && idle) begin
      act_q    <= act_pend_val;
      act_pend <= 1'b0;
    end
  end

  pe_result_skid #(
    .TAG_W (TAG_W),
    .IDX_W (IDX_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (cap_fire),
    .in_ready  (res_in_ready),
    .in_data   (cap_data),
    .in_tag    (tag_q[gnt_ptr]),
    .in_pe     (gnt_ptr),
    .out_valid (res_valid),
    .out_ready (res_ready),
    .out_data  (res_data),
    .out_tag   (res_tag),
    .out_pe    (res_pe)
  );

endmodule

// File: tb/tb_pe_array_scheduler.sv
// Scoreboard bench for pe_array_scheduler: behavioural PE models plus an
// in-order expected-result queue drained by an independent monitor.
module tb_pe_array_scheduler;

  localparam int NUM_PE = 4;
  localparam int TAG_W  = 8;
  localparam int IDX_W  = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 job_valid = 1'b0;
  logic                 job_ready;
  logic [15:0]          job_input = '0;
  logic [15:0]          job_weight = '0;
  logic [TAG_W-1:0]     job_tag = '0;
  logic [NUM_PE-1:0]    pe_in_valid, pe_wt_valid;
  logic [15:0]          pe_in_data, pe_wt_data;
  logic [NUM_PE-1:0]    pe_in_ready = '0;
  logic [NUM_PE-1:0]    pe_wt_ready = '0;
  logic [40*NUM_PE-1:0] pe_out_data = '0;
  logic [NUM_PE-1:0]    pe_out_valid = '0;
  logic [NUM_PE-1:0]    pe_out_ready;
  logic                 res_valid;
  logic                 res_ready = 1'b0;
  logic [39:0]          res_data;
  logic [TAG_W-1:0]     res_tag;
  logic [IDX_W-1:0]     res_pe;
  logic [1:0]           cfg_act_type = '0;
  logic                 cfg_act_we = 1'b0;
  logic [1:0]           pe_act_type;
  logic                 idle;

  typedef struct { logic [15:0] in_d; logic [15:0] wt_d; logic [7:0] tag; } job_t;
  typedef struct { logic [7:0] tag; logic [39:0] data; int pe; } exp_t;

  job_t        send_q[$];
  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_fail = 0;
  int          acc_cnt = 0;
  bit          rand_mode = 1'b0;
  bit          res_ready_force = 1'b1;
  bit [NUM_PE-1:0] pe_release = '1;
  bit          m_busy [NUM_PE];
  int          m_lat  [NUM_PE];
  logic [39:0] m_res  [NUM_PE];

  pe_array_scheduler #(.NUM_PE(NUM_PE), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_input(job_input), .job_weight(job_weight), .job_tag(job_tag),
    .pe_in_valid(pe_in_valid), .pe_wt_valid(pe_wt_valid),
    .pe_in_data(pe_in_data), .pe_wt_data(pe_wt_data),
    .pe_in_ready(pe_in_ready), .pe_wt_ready(pe_wt_ready),
    .pe_out_data(pe_out_data), .pe_out_valid(pe_out_valid), .pe_out_ready(pe_out_ready),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_tag(res_tag), .res_pe(res_pe),
    .cfg_act_type(cfg_act_type), .cfg_act_we(cfg_act_we),
    .pe_act_type(pe_act_type), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic [7:0] tag);
    job_t j;
    j.in_d = a; j.wt_d = b; j.tag = tag;
    send_q.push_back(j);
  endtask

  task automatic tick();
    @(negedge clk);
    #4;
  endtask

  task automatic clearModel();
    send_q.delete();
    sb_q.delete();
    acc_cnt = 0;
    for (int i = 0; i < NUM_PE; i++) begin
      m_busy[i] = 1'b0;
      m_lat[i]  = 0;
    end
  endtask

  task automatic applyReset(input int cycles);
    rst = 1'b1;
    clearModel();
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  task automatic waitDrain(input string name, input int limit);
    int k = 0;
    while (!(send_q.size() == 0 && sb_q.size() == 0 && idle === 1'b1) && k < limit) begin
      tick();
      k++;
    end
    checkOutput({name, "_drained"}, 64'(k < limit), 64'd1);
  endtask

  // Drive at the falling edge, then record which handshakes the next rising
  // edge will complete; the k-th accepted job belongs on PE k mod NUM_PE.
  always @(negedge clk) begin : drv
    job_t j;
    exp_t e;
    if (rst) begin
      job_valid    = 1'b0;
      pe_in_ready  = '0;
      pe_wt_ready  = '0;
      pe_out_valid = '0;
      res_ready    = 1'b0;
      for (int i = 0; i < NUM_PE; i++) m_busy[i] = 1'b0;
    end else begin
      job_valid = (send_q.size() > 0) && (!rand_mode || ($urandom_range(0, 3) != 0));
      if (send_q.size() > 0) begin
        job_input  = send_q[0].in_d;
        job_weight = send_q[0].wt_d;
        job_tag    = send_q[0].tag;
      end
      for (int i = 0; i < NUM_PE; i++) begin
        pe_in_ready[i]  = !m_busy[i] && (!rand_mode || ($urandom_range(0, 3) != 0));
        pe_wt_ready[i]  = !m_busy[i] && (!rand_mode || ($urandom_range(0, 3) != 0));
        pe_out_valid[i] = m_busy[i] && (m_lat[i] == 0) && pe_release[i];
        pe_out_data[i*40 +: 40] = m_res[i];
      end
      res_ready = rand_mode ? ($urandom_range(0, 2) != 0) : res_ready_force;
    end
    #1;
    if (!rst) begin
      if (job_valid && job_ready) begin
        j = send_q.pop_front();
        e.tag  = j.tag;
        e.data = 40'(j.in_d) * 40'(j.wt_d);
        e.pe   = acc_cnt % NUM_PE;
        sb_q.push_back(e);
        acc_cnt++;
      end
      for (int i = 0; i < NUM_PE; i++) begin
        if (pe_out_valid[i] && pe_out_ready[i]) m_busy[i] = 1'b0;
        else if (m_busy[i] && m_lat[i] > 0) m_lat[i]--;
        if (pe_in_valid[i] && pe_wt_valid[i] && pe_in_ready[i] && pe_wt_ready[i]) begin
          m_busy[i] = 1'b1;
          m_res[i]  = 40'(pe_in_data) * 40'(pe_wt_data);
          m_lat[i]  = rand_mode ? int'($urandom_range(0, 4)) : 1;
        end
      end
    end
  end

  always @(negedge clk) begin : mon
    exp_t e;
    #2;
    if (!rst && res_valid && res_ready) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("[TB] FAIL unexpected_result: got tag 0x%0h, expected no result", res_tag);
      end else begin
        e = sb_q.pop_front();
        checkOutput("res_data", 64'(res_data), 64'(e.data));
        checkOutput("res_tag",  64'(res_tag),  64'(e.tag));
        checkOutput("res_pe",   64'(res_pe),   64'(e.pe));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    tick();
    checkOutput("job_ready_in_reset", 64'(job_ready), 64'd0);
    rst = 1'b0;
    tick();
    checkOutput("rst_job_ready",   64'(job_ready),    64'd1);
    checkOutput("rst_pe_in_valid", 64'(pe_in_valid),  64'd0);
    checkOutput("rst_pe_out_rdy",  64'(pe_out_ready), 64'd0);
    checkOutput("rst_res_valid",   64'(res_valid),    64'd0);
    checkOutput("rst_res_fields",  64'({res_data, res_tag, res_pe}), 64'd0);
    checkOutput("rst_act_type",    64'(pe_act_type),  64'd0);
    checkOutput("rst_idle",        64'(idle),         64'd1);

    applyStimulus(16'd3, 16'd5, 8'h11);
    waitDrain("single_job", 50);
    checkOutput("single_res_data", 64'(res_data), 64'd15);
    checkOutput("single_res_tag",  64'(res_tag),  64'h11);
    checkOutput("single_idle",     64'(idle),     64'd1);

    // Four jobs held in the PEs, then released out of order 3,0,2,1.
    applyReset(1);
    pe_release = '0;
    for (int t = 1; t <= 4; t++) applyStimulus(16'($urandom), 16'($urandom), 8'(t));
    repeat (8) tick();
    applyStimulus(16'($urandom), 16'($urandom), 8'd5);
    repeat (3) tick();
    checkOutput("full_job_ready", 64'(job_ready), 64'd0);
    pe_release[3] = 1'b1;
    repeat (3) tick();
    checkOutput("ooo_pe_out_ready", 64'(pe_out_ready), 64'b0001);
    checkOutput("ooo_res_valid",    64'(res_valid),    64'd0);
    pe_release[0] = 1'b1;
    repeat (3) tick();
    pe_release[2] = 1'b1;
    repeat (3) tick();
    pe_release[1] = 1'b1;
    waitDrain("ooo", 100);

    // Held result backs up the next PE's handshake.
    applyReset(1);
    res_ready_force = 1'b0;
    pe_release = '1;
    applyStimulus(16'd7, 16'd9, 8'hA0);
    applyStimulus(16'd11, 16'd13, 8'hA1);
    repeat (8) tick();
    checkOutput("stall_res_valid",  64'(res_valid),    64'd1);
    checkOutput("stall_res_pe",     64'(res_pe),       64'd0);
    checkOutput("stall_pe_out_rdy", 64'(pe_out_ready), 64'b0000);
    res_ready_force = 1'b1;
    tick();
    checkOutput("unstall_pe_out_rdy", 64'(pe_out_ready), 64'b0010);
    waitDrain("stall", 50);

    // Activation write while busy stays pending and blocks new jobs.
    pe_release = '0;
    applyStimulus(16'($urandom), 16'($urandom), 8'hC0);
    applyStimulus(16'($urandom), 16'($urandom), 8'hC1);
    repeat (4) tick();
    cfg_act_type = 2'b01;
    cfg_act_we   = 1'b1;
    tick();
    cfg_act_we   = 1'b0;
    applyStimulus(16'($urandom), 16'($urandom), 8'hC2);
    tick();
    checkOutput("cfg_pend_act",   64'(pe_act_type), 64'd0);
    checkOutput("cfg_pend_ready", 64'(job_ready),   64'd0);
    pe_release = '1;
    k = 0;
    while (idle !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    checkOutput("cfg_idle_seen",     64'(k < 50),      64'd1);
    checkOutput("cfg_act_at_idle",   64'(pe_act_type), 64'd0);
    checkOutput("cfg_ready_at_idle", 64'(job_ready),   64'd0);
    tick();
    checkOutput("cfg_act_applied",   64'(pe_act_type), 64'd1);
    waitDrain("cfg", 50);

    // Reset with three jobs outstanding.
    pe_release = '0;
    for (int t = 0; t < 3; t++) applyStimulus(16'($urandom), 16'($urandom), 8'($urandom));
    repeat (6) tick();
    checkOutput("midrst_busy_idle", 64'(idle), 64'd0);
    rst = 1'b1;
    clearModel();
    tick();
    checkOutput("midrst_pe_in_valid", 64'(pe_in_valid),  64'd0);
    checkOutput("midrst_pe_out_rdy",  64'(pe_out_ready), 64'd0);
    checkOutput("midrst_res_valid",   64'(res_valid),    64'd0);
    checkOutput("midrst_idle",        64'(idle),         64'd1);
    checkOutput("midrst_act_type",    64'(pe_act_type),  64'd0);
    rst = 1'b0;
    pe_release = '1;
    tick();
    checkOutput("midrst_job_ready", 64'(job_ready), 64'd1);

    // Randomised traffic with random PE latency and backpressure.
    rand_mode = 1'b1;
    for (int t = 0; t < 300; t++) applyStimulus(16'($urandom), 16'($urandom), 8'($urandom));
    waitDrain("random", 20000);
    rand_mode = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
